// File: rtl/bullet_pool.sv
// Pool of N_BULLETS projectiles fed by one fire source: edge-triggered spawn with
// frame cooldown, per-frame motion, off-screen/hit retirement and rectangle rendering.
module bullet_pool #(
    parameter int                   N_BULLETS    = 4,
    parameter int                   SCREEN_CORDW = 16,
    parameter int                   COLR_BITS    = 4,
    parameter int                   H_RES        = 640,
    parameter int                   V_RES        = 480,
    parameter int                   BULLET_W     = 4,
    parameter int                   BULLET_H     = 30,
    parameter int                   SPEED        = 8,
    parameter int                   COOLDOWN     = 8,
    parameter bit                   DIR_UP       = 1'b1,
    parameter logic [COLR_BITS-1:0] COLR         = 'hF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 frame,
    input  logic                                 fire,
    input  logic signed [SCREEN_CORDW-1:0]       origin_x,
    input  logic signed [SCREEN_CORDW-1:0]       origin_y,
    input  logic [N_BULLETS-1:0]                 hit,
    input  logic signed [SCREEN_CORDW-1:0]       screen_x,
    input  logic signed [SCREEN_CORDW-1:0]       screen_y,
    output logic [N_BULLETS-1:0]                 active,
    output logic [N_BULLETS*SCREEN_CORDW-1:0]    bullets_x,
    output logic [N_BULLETS*SCREEN_CORDW-1:0]    bullets_y,
    output logic                                 fired,
    output logic                                 drawing,
    output logic [COLR_BITS-1:0]                 pixel
);

    localparam int CW   = SCREEN_CORDW;
    localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic signed [CW:0]   SPEED_E   = (CW+1)'(SPEED);
    localparam logic signed [CW:0]   BH_E      = (CW+1)'(BULLET_H);
    localparam logic signed [CW:0]   BW_E      = (CW+1)'(BULLET_W);
    localparam logic signed [CW:0]   EXIT_DN_E = (CW+1)'(V_RES - SPEED);
    localparam logic signed [CW:0]   HRES_E    = (CW+1)'(H_RES);
    localparam logic signed [CW:0]   VRES_E    = (CW+1)'(V_RES);
    localparam logic signed [CW:0]   ZERO_E    = '0;
    localparam logic signed [CW-1:0] STEP      = CW'(SPEED);

    logic signed [CW-1:0] pos_x [N_BULLETS];
    logic signed [CW-1:0] pos_y [N_BULLETS];
    logic                 fire_q;
    logic                 pending;
    logic [CD_W-1:0]      cooldown;
    logic [N_BULLETS-1:0] exits;
    logic [N_BULLETS-1:0] spawn_sel;
    logic                 spawn;
    logic                 draw_c;
    logic signed [CW:0]   sx_e;
    logic signed [CW:0]   sy_e;

    function automatic logic signed [CW:0] sext(input logic signed [CW-1:0] v);
        return $signed({v[CW-1], v});
    endfunction

    assign sx_e = sext(screen_x);
    assign sy_e = sext(screen_y);

    // One extra bit keeps y + BULLET_H from wrapping near the coordinate limits.
    always_comb begin
        exits = '0;
        for (int i = 0; i < N_BULLETS; i++) begin
            if (DIR_UP) exits[i] = (sext(pos_y[i]) + BH_E) <= SPEED_E;
            else        exits[i] = sext(pos_y[i]) >= EXIT_DN_E;
        end
    end

    // Lowest slot that is free at the start of the cycle; a slot hit this cycle is skipped.
    always_comb begin
        spawn_sel = '0;
        for (int i = N_BULLETS - 1; i >= 0; i--) begin
            if (!active[i] && !hit[i]) begin
                spawn_sel    = '0;
                spawn_sel[i] = 1'b1;
            end
        end
        spawn = frame && pending && (cooldown == '0) && (spawn_sel != '0);
    end

    always_comb begin
        draw_c = 1'b0;
        for (int i = 0; i < N_BULLETS; i++) begin
            if (active[i] &&
                sext(pos_x[i]) <= sx_e && sx_e < sext(pos_x[i]) + BW_E &&
                sext(pos_y[i]) <= sy_e && sy_e < sext(pos_y[i]) + BH_E)
                draw_c = 1'b1;
        end
        // Nothing is drawn while the beam is outside the visible area.
        if (sx_e < ZERO_E || sx_e >= HRES_E || sy_e < ZERO_E || sy_e >= VRES_E)
            draw_c = 1'b0;
    end

    always_comb begin
        bullets_x = '0;
        bullets_y = '0;
        for (int i = 0; i < N_BULLETS; i++) begin
            bullets_x[i*CW +: CW] = pos_x[i];
            bullets_y[i*CW +: CW] = pos_y[i];
        end
    end

    // fire_q resets high so a fire level held through reset is not taken as a new edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fire_q   <= 1'b1;
            pending  <= 1'b0;
            cooldown <= '0;
            fired    <= 1'b0;
            drawing  <= 1'b0;
            pixel    <= '0;
            active   <= '0;
            for (int i = 0; i < N_BULLETS; i++) begin
                pos_x[i] <= '0;
                pos_y[i] <= '0;
            end
        end else begin
            fire_q  <= fire;
            fired   <= spawn;
            drawing <= draw_c;
            pixel   <= draw_c ? COLR : '0;

            if (fire && !fire_q) pending <= 1'b1;
            else if (frame)      pending <= 1'b0;

            if (spawn)                          cooldown <= CD_W'(COOLDOWN);
            else if (frame && cooldown != '0)   cooldown <= cooldown - CD_W'(1);

            for (int i = 0; i < N_BULLETS; i++) begin
                if (hit[i] || (frame && active[i] && exits[i])) begin
                    active[i] <= 1'b0;
                end else if (frame && active[i]) begin
                    pos_y[i] <= DIR_UP ? pos_y[i] - STEP : pos_y[i] + STEP;
                end else if (spawn && spawn_sel[i]) begin
                    active[i] <= 1'b1;
                    pos_x[i]  <= origin_x;
                    pos_y[i]  <= origin_y;
                end
            end
        end
    end

endmodule

// File: tb/tb_bullet_pool.sv
// Self-checking bench for bullet_pool: spawn, cooldown, pool full, retire, hit,
// rendering through an expected-value queue, and mid-operation reset.
module tb_bullet_pool;

    localparam int N  = 4;
    localparam int CW = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 frame = 1'b0;
    logic                 fire = 1'b0;
    logic signed [CW-1:0] origin_x = '0;
    logic signed [CW-1:0] origin_y = '0;
    logic signed [CW-1:0] screen_x = '0;
    logic signed [CW-1:0] screen_y = '0;
    logic [N-1:0]         hit = '0;
    logic [N-1:0]         active;
    logic [N*CW-1:0]      bullets_x;
    logic [N*CW-1:0]      bullets_y;
    logic                 fired;
    logic                 drawing;
    logic [3:0]           pixel;

    int tests = 0;
    int fails = 0;
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    bullet_pool #(
        .N_BULLETS(4), .SCREEN_CORDW(16), .COLR_BITS(4), .H_RES(640), .V_RES(480),
        .BULLET_W(4), .BULLET_H(30), .SPEED(8), .COOLDOWN(8), .DIR_UP(1'b1), .COLR(4'hF)
    ) dut (
        .clk(clk), .rst(rst), .frame(frame), .fire(fire),
        .origin_x(origin_x), .origin_y(origin_y), .hit(hit),
        .screen_x(screen_x), .screen_y(screen_y), .active(active),
        .bullets_x(bullets_x), .bullets_y(bullets_y), .fired(fired),
        .drawing(drawing), .pixel(pixel)
    );

    function automatic logic signed [CW-1:0] slot_x(input int i);
        return bullets_x[i*CW +: CW];
    endfunction

    function automatic logic signed [CW-1:0] slot_y(input int i);
        return bullets_y[i*CW +: CW];
    endfunction

    // Reference rectangle test for a single bullet at (bx,by), 4x30, inside 640x480.
    function automatic logic [4:0] exp_px(input int sx, input int sy, input int bx, input int by);
        logic in_rect;
        in_rect = (sx >= bx) && (sx < bx + 4) && (sy >= by) && (sy < by + 30) &&
                  (sx >= 0) && (sx < 640) && (sy >= 0) && (sy < 480);
        return in_rect ? 5'b1_1111 : 5'b0_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        tick();
        frame = 1'b0;
    endtask

    task automatic run_frames(input int n);
        for (int k = 0; k < n; k++) begin
            pulse_frame();
            tick();
        end
    endtask

    task automatic fire_edge();
        fire = 1'b0;
        tick();
        fire = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        tests++; if (active !== 4'b0000) begin fails++; $display("FAIL reset_active: got %b want 0000", active); end
        tests++; if (bullets_x !== '0 || bullets_y !== '0) begin fails++; $display("FAIL reset_pos: got x=%h y=%h want 0", bullets_x, bullets_y); end
        tests++; if ({fired, drawing, pixel} !== 6'b0) begin fails++; $display("FAIL reset_outs: got fired=%b drawing=%b pixel=%h want 0", fired, drawing, pixel); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_spawn();
        origin_x = 16'sd100;
        origin_y = 16'sd400;
        fire_edge();
        pulse_frame();
        tests++; if (fired !== 1'b1) begin fails++; $display("FAIL t1_fired: got %b want 1", fired); end
        tests++; if (active !== 4'b0001) begin fails++; $display("FAIL t1_active: got %b want 0001", active); end
        tests++; if (slot_x(0) !== 16'sd100 || slot_y(0) !== 16'sd400) begin fails++; $display("FAIL t1_pos: got (%0d,%0d) want (100,400)", slot_x(0), slot_y(0)); end
        tick();
        tests++; if (fired !== 1'b0) begin fails++; $display("FAIL t1_fired_pulse: got %b want 0", fired); end
    endtask

    task automatic test_cooldown();
        pulse_frame();
        tests++; if (slot_y(0) !== 16'sd392) begin fails++; $display("FAIL t2_move: got %0d want 392", slot_y(0)); end
        tests++; if (active !== 4'b0001 || fired !== 1'b0) begin fails++; $display("FAIL t2_hold: got active=%b fired=%b want 0001/0", active, fired); end
        fire_edge();
        pulse_frame();
        tests++; if (fired !== 1'b0 || active !== 4'b0001) begin fails++; $display("FAIL t2_cooldown_drop: got fired=%b active=%b want 0/0001", fired, active); end
        run_frames(6);
        fire_edge();
        pulse_frame();
        tests++; if (fired !== 1'b1 || active !== 4'b0011) begin fails++; $display("FAIL t2_respawn: got fired=%b active=%b want 1/0011", fired, active); end
        tests++; if (slot_x(1) !== 16'sd100 || slot_y(1) !== 16'sd400) begin fails++; $display("FAIL t2_slot1_pos: got (%0d,%0d) want (100,400)", slot_x(1), slot_y(1)); end
        tests++; if (slot_y(0) !== 16'sd328) begin fails++; $display("FAIL t2_slot0_y: got %0d want 328", slot_y(0)); end
    endtask

    task automatic test_pool_full();
        run_frames(8);
        fire_edge();
        pulse_frame();
        run_frames(8);
        fire_edge();
        pulse_frame();
        tests++; if (active !== 4'b1111) begin fails++; $display("FAIL t3_full: got %b want 1111", active); end
        tests++; if (slot_y(0) !== 16'sd184) begin fails++; $display("FAIL t3_slot0_y: got %0d want 184", slot_y(0)); end
        run_frames(8);
        fire_edge();
        pulse_frame();
        tests++; if (fired !== 1'b0 || active !== 4'b1111) begin fails++; $display("FAIL t3_drop: got fired=%b active=%b want 0/1111", fired, active); end
        hit = 4'b1000;
        tick();
        hit = 4'b0000;
        tests++; if (active !== 4'b0111) begin fails++; $display("FAIL t3_hit: got %b want 0111", active); end
        pulse_frame();
        tests++; if (fired !== 1'b0 || active !== 4'b0111) begin fails++; $display("FAIL t3_pending_clear: got fired=%b active=%b want 0/0111", fired, active); end
    endtask

    task automatic test_retire();
        do_reset();
        origin_x = 16'sd50;
        origin_y = 16'sd42;
        fire_edge();
        pulse_frame();
        run_frames(8);
        tests++; if (active !== 4'b0001 || slot_y(0) !== -16'sd22) begin fails++; $display("FAIL t4_edge_alive: got active=%b y=%0d want 0001/-22", active, slot_y(0)); end
        origin_x = 16'sd200;
        origin_y = 16'sd300;
        fire_edge();
        pulse_frame();
        tests++; if (active !== 4'b0010 || fired !== 1'b1) begin fails++; $display("FAIL t4_retire_spawn: got active=%b fired=%b want 0010/1", active, fired); end
        tests++; if (slot_x(1) !== 16'sd200 || slot_y(1) !== 16'sd300) begin fails++; $display("FAIL t4_slot1_pos: got (%0d,%0d) want (200,300)", slot_x(1), slot_y(1)); end
        run_frames(8);
        fire = 1'b0;
        tick();
        fire = 1'b1;
        frame = 1'b1;
        tick();
        frame = 1'b0;
        tests++; if (fired !== 1'b0 || active !== 4'b0010) begin fails++; $display("FAIL t4_edge_on_frame: got fired=%b active=%b want 0/0010", fired, active); end
        pulse_frame();
        tests++; if (fired !== 1'b1 || active !== 4'b0011) begin fails++; $display("FAIL t4_served_next: got fired=%b active=%b want 1/0011", fired, active); end
        tests++; if (slot_y(1) !== 16'sd220) begin fails++; $display("FAIL t4_slot1_y: got %0d want 220", slot_y(1)); end
    endtask

    task automatic test_hit();
        run_frames(8);
        origin_x = 16'sd300;
        origin_y = 16'sd250;
        fire_edge();
        pulse_frame();
        tests++; if (active !== 4'b0111 || slot_y(2) !== 16'sd250) begin fails++; $display("FAIL t5_spawn2: got active=%b y2=%0d want 0111/250", active, slot_y(2)); end
        hit = 4'b0100;
        frame = 1'b1;
        tick();
        hit = 4'b0000;
        frame = 1'b0;
        tests++; if (active !== 4'b0011) begin fails++; $display("FAIL t5_hit_frame: got %b want 0011", active); end
        tests++; if (slot_y(2) !== 16'sd250) begin fails++; $display("FAIL t5_hit_nomove: got %0d want 250", slot_y(2)); end
        tests++; if (slot_y(0) !== 16'sd220) begin fails++; $display("FAIL t5_others_move: got %0d want 220", slot_y(0)); end
        hit = 4'b1000;
        tick();
        hit = 4'b0000;
        tests++; if (active !== 4'b0011 || slot_x(3) !== 16'sd0 || slot_y(3) !== 16'sd0) begin fails++; $display("FAIL t5_hit_inactive: got active=%b pos3=(%0d,%0d) want 0011/(0,0)", active, slot_x(3), slot_y(3)); end
    endtask

    task automatic scan(input int sx, input int sy);
        logic [4:0] e;
        screen_x = 16'(sx);
        screen_y = 16'(sy);
        exp_q.push_back(exp_px(sx, sy, 100, 300));
        tick();
        e = exp_q.pop_front();
        tests++;
        if ({drawing, pixel} !== e) begin
            fails++;
            $display("FAIL t6_render(%0d,%0d): got drawing=%b pixel=%h want %b/%h", sx, sy, drawing, pixel, e[4], e[3:0]);
        end
    endtask

    task automatic test_render();
        do_reset();
        origin_x = 16'sd100;
        origin_y = 16'sd300;
        fire_edge();
        pulse_frame();
        tests++; if (active !== 4'b0001) begin fails++; $display("FAIL t6_setup: got %b want 0001", active); end
        scan(103, 300);
        scan(104, 300);
        scan(99, 300);
        scan(100, 329);
        scan(100, 330);
        scan(100, 299);
        for (int k = 0; k < 24; k++) scan($urandom_range(94, 110), $urandom_range(294, 336));
        scan(101, 310);
        rst = 1'b0;
        #1;
        tests++; if (active !== 4'b0000 || bullets_x !== '0 || bullets_y !== '0) begin fails++; $display("FAIL t6_midreset_state: got active=%b x=%h y=%h want 0", active, bullets_x, bullets_y); end
        tests++; if ({fired, drawing, pixel} !== 6'b0) begin fails++; $display("FAIL t6_midreset_outs: got fired=%b drawing=%b pixel=%h want 0", fired, drawing, pixel); end
        tick();
        rst = 1'b1;
        tick();
        pulse_frame();
        tests++; if (fired !== 1'b0 || active !== 4'b0000) begin fails++; $display("FAIL t6_no_spawn_after_reset: got fired=%b active=%b want 0/0000", fired, active); end
        fire_edge();
        pulse_frame();
        tests++; if (fired !== 1'b1 || active !== 4'b0001) begin fails++; $display("FAIL t6_new_edge: got fired=%b active=%b want 1/0001", fired, active); end
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_cooldown();
        test_pool_full();
        test_retire();
        test_hit();
        test_render();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
